menu_video_timing: RTL
======================

# menu_video_timing

Raster timing generator for the menu core's video path, clocked by the video clock. It produces the pixel enable, horizontal and vertical counters, and blank/sync flags, plus a per-frame scroll offset. It feeds the noise/cosine shading stage directly and drives CE_PIXEL, VGA_HS, VGA_VS and VGA_DE. PAL/NTSC and scandoubler mode changes take effect only at frame boundaries, so a frame is never torn.

## Interface
Parameters:
- H_LAST, 637: last horizontal count; the line is H_LAST+1 pixels.
- HBL_START, 529: first horizontally blanked count.
- HS_START, 544: first hsync count. This count also samples the vertical flags.
- HS_END, 590: first count after hsync.
- OFS_STEP, 6: frame_ofs increment per frame.

Ports:
- clk  in  1  video clock (CLK_VIDEO domain).
- reset  in  1  synchronous, active-high reset.
- pal  in  1  PAL request. Sampled at frame boundary.
- scandbl  in  1  forced_scandoubler request. Sampled at frame boundary.
- ce_pix  out  1  pixel enable.
- hc  out  10  horizontal count.
- vc  out  10  vertical count.
- vline  out  10  source line: vc>>1 when scandoubling, else vc.
- frame_ofs  out  10  scroll offset; adds OFS_STEP per frame and wraps mod 1024.
- hblank, vblank, hsync, vsync  out  1 each  registered raster flags.
- de  out  1  ~(hblank|vblank).
- frame_start  out  1  one-clk pulse on vc wrap.
- mode_pal, mode_sd  out  1 each  latched mode in force.

## Operation
- **Reset:** on the clk edge with reset high:
  - hc, vc, frame_ofs ← 0.
  - ce_pix, all flags, frame_start ← 0.
  - mode_pal ← pal, mode_sd ← scandbl.
- **ce_pix:**
  - mode_sd=1: ce_pix ← 1 every clk.
  - mode_sd=0: ce_pix toggles, giving a 1-in-2 rate.
- **Counters:** advance only on clk edges where ce_pix=1.
  - hc: 0..H_LAST, then wraps to 0.
  - On hc wrap, vc increments up to V_LAST, then wraps to 0.
- **V_LAST by mode (pal/sd):**
  - 0/0: 261
  - 0/1: 523
  - 1/0: 311
  - 1/1: 623
- **On vc wrap (same edge):**
  - frame_ofs ← frame_ofs + OFS_STEP (10-bit wrap).
  - mode_pal ← pal, mode_sd ← scandbl.
  - frame_start ← 1 for exactly one clk.
- **Horizontal flags,** updated every clk (not ce-gated):
  - hblank ← 1 when hc==HBL_START; ← 0 when hc==0.
  - hsync ← 1 when hc==HS_START; ← 0 when hc==HS_END.
- **Vertical flags,** updated only on clks where hc==HS_START:
  - NTSC vblank set at vc==240 (sd 480). NTSC vsync set at 245 (sd 490), cleared at 248 (sd 496).
  - PAL vblank set at vc==300 (sd 601). PAL vsync set at 304 (sd 609), cleared at 308 (sd 617).
  - vblank cleared at vc==0 in all modes.
- vline uses mode_sd, not scandbl.
- **Input changes:** pal/scandbl changes mid-frame have no effect until the next vc wrap. The current frame completes with its old V_LAST and old thresholds.

## Timing
- Flags and frame_start are registered: each lags the triggering counter value by one clk.
- de is combinational from registered flags, so it adds zero extra latency.
- Line length:
  - (H_LAST+1)=638 ce_pix pulses.
  - 1276 clks non-sd; 638 clks sd.
- hsync width: 46 pixels (hc 544..589).
- Frame length in clks:
  - NTSC: 262×1276 = 334312 (non-sd); 524×638 = 334312 (sd).
  - PAL: 312×1276 = 398112 (non-sd); 624×638 = 398112 (sd).
- First ce_pix after reset release: mode_sd=1 → the next clk; mode_sd=0 → the next clk too (toggle 0→1).
- Reset mid-line or mid-frame: all state returns to reset values on that edge. No partial line is emitted.
- Simultaneous hc wrap and vc wrap:
  - The frame_ofs update, mode latch and frame_start all occur on that one edge.
  - The new mode governs ce_pix from the following clk.
- Switching scandbl 1→0 at the boundary: ce_pix register value carries over, then resumes toggling.

## Test plan
- NTSC, non-sd: reset, run → frame_start pulses 334312 clks apart; vc peaks at 261; vsync high for 3 lines × 1276 clks.
- PAL, sd: reset with pal=1, scandbl=1 → ce_pix constantly 1; vc peaks at 623; frame_start period 398112; vblank asserts at vc=601.
- Mode change mid-frame: at vc=100 raise pal → vc still wraps after 261; mode_pal=1 from the wrap edge; next frame wraps after 311.
- Wrap arithmetic: run 171 frames → frame_ofs = 1026 mod 1024 = 2. In sd mode, vline=vc>>1 (vc=523 → vline=261).
- Horizontal flags: hsync rises 1 clk after hc becomes 544 and falls 1 clk after hc becomes 590; hblank covers hc 529..637; de=0 whenever either blank is set.
- Reset mid-operation: assert reset at hc=300, vc=150 for 1 clk → next edge shows all outputs 0 (flags, hc, vc, frame_ofs); counting restarts from 0 and the first frame_start arrives 334312 clks later (NTSC non-sd).

Source files
------------

// File: rtl/menu_video_timing_if.sv
// Raster timing bundle between the menu video timing generator and its consumers.
// master = timing generator, slave = shading stage / video output.
interface menu_video_timing_if;
  logic       pal;
  logic       scandbl;
  logic       ce_pix;
  logic [9:0] hc;
  logic [9:0] vc;
  logic [9:0] vline;
  logic [9:0] frame_ofs;
  logic       hblank;
  logic       vblank;
  logic       hsync;
  logic       vsync;
  logic       de;
  logic       frame_start;
  logic       mode_pal;
  logic       mode_sd;

  modport master (
    input  pal, scandbl,
    output ce_pix, hc, vc, vline, frame_ofs,
           hblank, vblank, hsync, vsync, de, frame_start, mode_pal, mode_sd
  );

  modport slave (
    output pal, scandbl,
    input  ce_pix, hc, vc, vline, frame_ofs,
           hblank, vblank, hsync, vsync, de, frame_start, mode_pal, mode_sd
  );
endinterface

// File: rtl/menu_video_timing.sv
// Raster timing generator for the menu video path: pixel enable, h/v counters,
// registered blank/sync flags and a per-frame scroll offset; mode changes only at frame wrap.
module menu_video_timing #(
  parameter int H_LAST    = 637,
  parameter int HBL_START = 529,
  parameter int HS_START  = 544,
  parameter int HS_END    = 590,
  parameter int OFS_STEP  = 6
) (
  input logic                 clk,
  input logic                 reset,
  menu_video_timing_if.master vt
);

  localparam logic [9:0] H_LAST_C    = 10'(H_LAST);
  localparam logic [9:0] HBL_START_C = 10'(HBL_START);
  localparam logic [9:0] HS_START_C  = 10'(HS_START);
  localparam logic [9:0] HS_END_C    = 10'(HS_END);
  localparam logic [9:0] OFS_STEP_C  = 10'(OFS_STEP);

  logic       ce_pix_q;
  logic [9:0] hc_q;
  logic [9:0] vc_q;
  logic [9:0] frame_ofs_q;
  logic       hblank_q;
  logic       vblank_q;
  logic       hsync_q;
  logic       vsync_q;
  logic       frame_start_q;
  logic       mode_pal_q;
  logic       mode_sd_q;

  logic [9:0] v_last;
  logic [9:0] vbl_set;
  logic [9:0] vs_set;
  logic [9:0] vs_clr;
  logic       h_wrap;
  logic       v_wrap;

  // Vertical geometry comes from the latched mode, so a frame keeps its thresholds to the end
  always_comb begin
    v_last  = 10'd261;
    vbl_set = 10'd240;
    vs_set  = 10'd245;
    vs_clr  = 10'd248;
    unique case ({mode_pal_q, mode_sd_q})
      2'b00: begin v_last = 10'd261; vbl_set = 10'd240; vs_set = 10'd245; vs_clr = 10'd248; end
      2'b01: begin v_last = 10'd523; vbl_set = 10'd480; vs_set = 10'd490; vs_clr = 10'd496; end
      2'b10: begin v_last = 10'd311; vbl_set = 10'd300; vs_set = 10'd304; vs_clr = 10'd308; end
      2'b11: begin v_last = 10'd623; vbl_set = 10'd601; vs_set = 10'd609; vs_clr = 10'd617; end
    endcase
  end

  assign h_wrap = ce_pix_q && (hc_q == H_LAST_C);
  assign v_wrap = h_wrap && (vc_q == v_last);

  always_ff @(posedge clk) begin
    if (reset) begin
      ce_pix_q      <= 1'b0;
      hc_q          <= '0;
      vc_q          <= '0;
      frame_ofs_q   <= '0;
      hblank_q      <= 1'b0;
      vblank_q      <= 1'b0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      frame_start_q <= 1'b0;
      mode_pal_q    <= vt.pal;
      mode_sd_q     <= vt.scandbl;
    end else begin
      ce_pix_q      <= mode_sd_q ? 1'b1 : ~ce_pix_q;
      frame_start_q <= v_wrap;

      if (ce_pix_q) hc_q <= h_wrap ? 10'd0 : hc_q + 10'd1;
      if (h_wrap)   vc_q <= v_wrap ? 10'd0 : vc_q + 10'd1;

      if (v_wrap) begin
        frame_ofs_q <= frame_ofs_q + OFS_STEP_C;
        mode_pal_q  <= vt.pal;
        mode_sd_q   <= vt.scandbl;
      end

      // Horizontal flags run every clk; in 1-in-2 mode they simply re-evaluate the same count
      if (hc_q == HBL_START_C)  hblank_q <= 1'b1;
      else if (hc_q == 10'd0)   hblank_q <= 1'b0;

      if (hc_q == HS_START_C)   hsync_q <= 1'b1;
      else if (hc_q == HS_END_C) hsync_q <= 1'b0;

      if (hc_q == HS_START_C) begin
        if (vc_q == vbl_set)    vblank_q <= 1'b1;
        else if (vc_q == 10'd0) vblank_q <= 1'b0;
        if (vc_q == vs_set)      vsync_q <= 1'b1;
        else if (vc_q == vs_clr) vsync_q <= 1'b0;
      end
    end
  end

  assign vt.ce_pix      = ce_pix_q;
  assign vt.hc          = hc_q;
  assign vt.vc          = vc_q;
  assign vt.vline       = mode_sd_q ? {1'b0, vc_q[9:1]} : vc_q;
  assign vt.frame_ofs   = frame_ofs_q;
  assign vt.hblank      = hblank_q;
  assign vt.vblank      = vblank_q;
  assign vt.hsync       = hsync_q;
  assign vt.vsync       = vsync_q;
  assign vt.de          = ~(hblank_q | vblank_q);
  assign vt.frame_start = frame_start_q;
  assign vt.mode_pal    = mode_pal_q;
  assign vt.mode_sd     = mode_sd_q;

endmodule
